// File: rtl/ddr_wr_burst.sv
// ddr_wr_burst: streams 32-bit words into the MIG port-0 write FIFO and issues one
// WRITE command per group of words, walking a circular byte-address region.
`default_nettype none

module ddr_wr_burst #(
  parameter int          BURST_LEN = 32,
  parameter logic [29:0] ADDR_BASE = 30'h0000_0000,
  parameter logic [29:0] ADDR_SIZE = 30'h0400_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        calib_done,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic        mig_cmd_en,
  output logic [2:0]  mig_cmd_instr,
  output logic [5:0]  mig_cmd_bl,
  output logic [29:0] mig_cmd_byte_addr,
  input  logic        mig_cmd_full,
  output logic        mig_wr_en,
  output logic [3:0]  mig_wr_mask,
  output logic [31:0] mig_wr_data,
  input  logic        mig_wr_full,
  input  logic        mig_wr_error,
  output logic        busy,
  output logic        err,
  output logic [15:0] bursts_issued
);

  typedef enum logic [1:0] {
    WAIT_CALIB = 2'd0,
    FILL       = 2'd1,
    CMD        = 2'd2,
    ERROR      = 2'd3
  } state_t;

  localparam logic [6:0]  LAST_IDX  = 7'(BURST_LEN - 1);
  localparam logic [29:0] ADDR_MASK = ADDR_SIZE - 30'd1;

  state_t      state;
  logic [6:0]  word_cnt;
  logic [5:0]  pend_bl;
  logic [29:0] cur_addr;
  logic [29:0] burst_bytes;
  logic [29:0] next_addr;
  logic        accept;

  // Write path is a pure pass-through so data always reaches MIG before its command.
  assign s_ready     = (state == FILL) && !mig_wr_full;
  assign accept      = s_valid && s_ready;
  assign mig_wr_en   = accept;
  assign mig_wr_data = s_data;
  assign mig_wr_mask = 4'b0000;
  assign busy        = (state == CMD) || ((state == FILL) && (word_cnt != 7'd0));

  // The region size is a power of two, so wrapping is a mask on the offset.
  assign burst_bytes = {22'd0, pend_bl, 2'b00} + 30'd4;
  assign next_addr   = ADDR_BASE + (((cur_addr - ADDR_BASE) + burst_bytes) & ADDR_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= WAIT_CALIB;
      word_cnt          <= 7'd0;
      pend_bl           <= 6'd0;
      cur_addr          <= ADDR_BASE;
      mig_cmd_en        <= 1'b0;
      mig_cmd_instr     <= 3'b000;
      mig_cmd_bl        <= 6'd0;
      mig_cmd_byte_addr <= 30'd0;
      err               <= 1'b0;
      bursts_issued     <= 16'd0;
    end else begin
      mig_cmd_en <= 1'b0;
      if (mig_wr_error) begin
        err   <= 1'b1;
        state <= ERROR;
      end else begin
        case (state)
          WAIT_CALIB: begin
            if (calib_done) state <= FILL;
          end
          FILL: begin
            if (accept) begin
              if ((word_cnt == LAST_IDX) || s_last) begin
                pend_bl  <= word_cnt[5:0];
                word_cnt <= 7'd0;
                state    <= CMD;
              end else begin
                word_cnt <= word_cnt + 7'd1;
              end
            end
          end
          CMD: begin
            if (!mig_cmd_full) begin
              mig_cmd_en        <= 1'b1;
              mig_cmd_instr     <= 3'b000;
              mig_cmd_bl        <= pend_bl;
              mig_cmd_byte_addr <= cur_addr;
              bursts_issued     <= bursts_issued + 16'd1;
              cur_addr          <= next_addr;
              state             <= FILL;
            end
          end
          ERROR: begin
            state <= ERROR;
          end
          default: state <= ERROR;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ddr_wr_burst.sv
// tb_ddr_wr_burst: randomized stimulus checked every cycle against a group/offset
// level model of the write-burst feeder, plus literal expectations per scenario.
`default_nettype none

module tb_ddr_wr_burst;

  localparam int          BL   = 32;
  localparam logic [29:0] BASE = 30'h0;
  localparam logic [29:0] SIZE = 30'd256;

  logic        clk;
  logic        rst;
  logic        calib_done;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic        mig_cmd_en;
  logic [2:0]  mig_cmd_instr;
  logic [5:0]  mig_cmd_bl;
  logic [29:0] mig_cmd_byte_addr;
  logic        mig_cmd_full;
  logic        mig_wr_en;
  logic [3:0]  mig_wr_mask;
  logic [31:0] mig_wr_data;
  logic        mig_wr_full;
  logic        mig_wr_error;
  logic        busy;
  logic        err;
  logic [15:0] bursts_issued;

  ddr_wr_burst #(.BURST_LEN(BL), .ADDR_BASE(BASE), .ADDR_SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .calib_done(calib_done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .mig_cmd_en(mig_cmd_en), .mig_cmd_instr(mig_cmd_instr), .mig_cmd_bl(mig_cmd_bl),
    .mig_cmd_byte_addr(mig_cmd_byte_addr), .mig_cmd_full(mig_cmd_full),
    .mig_wr_en(mig_wr_en), .mig_wr_mask(mig_wr_mask), .mig_wr_data(mig_wr_data),
    .mig_wr_full(mig_wr_full), .mig_wr_error(mig_wr_error),
    .busy(busy), .err(err), .bursts_issued(bursts_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  bit wr_bp  = 0;
  bit cmd_bp = 0;

  // Model state: calibrated / errored flags, words in open group, pending group length,
  // region offset of the next burst, and the last command that should be on the bus.
  bit m_cal, m_err, m_pend, m_pulse;
  int m_cnt, m_len, m_off, m_bl, m_addr, m_issued;

  logic [31:0] wr_q[$];
  int cmd_bl_log[$];
  int cmd_addr_log[$];
  int cmd_cyc_log[$];
  int acc_cyc_log[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_cal = 0; m_err = 0; m_pend = 0; m_pulse = 0;
    m_cnt = 0; m_len = 0; m_off = 0; m_bl = 0; m_addr = 0; m_issued = 0;
  endfunction

  initial begin : compare
    bit exp_ready, exp_wr, exp_busy;
    model_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_ready = m_cal && !m_err && !m_pend && !mig_wr_full;
      exp_wr    = exp_ready && s_valid;
      exp_busy  = m_cal && !m_err && (m_pend || m_cnt != 0);
      check("s_ready",   32'(s_ready),           32'(exp_ready));
      check("wr_en",     32'(mig_wr_en),         32'(exp_wr));
      check("busy",      32'(busy),              32'(exp_busy));
      check("err",       32'(err),               32'(m_err));
      check("cmd_en",    32'(mig_cmd_en),        32'(m_pulse));
      check("cmd_bl",    32'(mig_cmd_bl),        32'(m_bl));
      check("cmd_addr",  32'(mig_cmd_byte_addr), 32'(m_addr));
      check("cmd_instr", 32'(mig_cmd_instr),     32'd0);
      check("wr_mask",   32'(mig_wr_mask),       32'd0);
      check("bursts",    32'(bursts_issued),     32'(m_issued));
      if (mig_wr_en === 1'b1) begin
        acc_cyc_log.push_back(cyc);
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_extra actual=%0h required=none cycle=%0d", mig_wr_data, cyc);
        end else begin
          check("wr_data", mig_wr_data, wr_q.pop_front());
        end
      end
      if (mig_cmd_en === 1'b1) begin
        cmd_bl_log.push_back(int'(mig_cmd_bl));
        cmd_addr_log.push_back(int'(mig_cmd_byte_addr));
        cmd_cyc_log.push_back(cyc);
      end
      if (rst) begin
        model_reset();
      end else begin
        m_pulse = 0;
        if (mig_wr_error) begin
          m_err = 1;
        end else if (m_err) begin
          m_err = 1;
        end else if (!m_cal) begin
          if (calib_done) m_cal = 1;
        end else if (m_pend) begin
          if (!mig_cmd_full) begin
            m_pulse  = 1;
            m_bl     = m_len - 1;
            m_addr   = int'(BASE) + m_off;
            m_issued = (m_issued + 1) % 65536;
            m_off    = (m_off + 4 * m_len) % int'(SIZE);
            m_pend   = 0;
          end
        end else if (exp_wr) begin
          m_cnt++;
          if (m_cnt == BL || s_last) begin
            m_pend = 1;
            m_len  = m_cnt;
            m_cnt  = 0;
          end
        end
      end
    end
  end

  // Background backpressure generators, active only when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mig_wr_full = wr_bp && ($urandom_range(1) == 1);
      if (cmd_bp) mig_cmd_full = ($urandom_range(3) == 0);
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; s_valid = 0; s_last = 0; calib_done = 0; mig_wr_error = 0;
    idle(2);
    rst = 0;
    wr_q.delete();
  endtask

  task automatic calibrate();
    calib_done = 1;
    idle(1);
  endtask

  task automatic send(int n, logic [31:0] d0, bit last_end, int gap_pct, int last_pct);
    for (int i = 0; i < n; i++) begin
      int t;
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 0;
        s_last  = ($urandom_range(1) == 1);
        s_data  = $urandom;
        idle(1);
      end
      s_data  = d0 + 32'(i);
      s_last  = (last_end && i == n - 1) || ($urandom_range(99) < last_pct);
      s_valid = 1;
      wr_q.push_back(s_data);
      t = 0;
      forever begin
        @(negedge clk);
        if (s_ready) begin
          idle(1);
          break;
        end
        t++;
        if (t > 500) break;
        idle(1);
      end
      if (t > 500) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout actual=%0d required=<=500 cycle=%0d", t, cyc);
        s_valid = 0; s_last = 0;
        return;
      end
    end
    s_valid = 0;
    s_last  = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c0, a0, rel;
    rst = 1; calib_done = 0; s_data = 0; s_valid = 0; s_last = 0;
    mig_cmd_full = 0; mig_wr_full = 0; mig_wr_error = 0;

    // Calibration gate
    do_reset();
    s_valid = 1; s_data = 32'hdead_beef;
    idle(100);
    check("t1_no_cmd", 32'(bursts_issued), 32'd0);
    s_valid = 0;
    calib_done = 1;
    @(posedge clk);
    @(negedge clk);
    check("t1_ready_after_calib", 32'(s_ready), 32'd1);
    idle(1);

    // Two full back-to-back bursts
    c0 = cmd_bl_log.size(); a0 = acc_cyc_log.size();
    send(64, 32'd0, 0, 0, 0);
    idle(5);
    check("t2_cmd_count", 32'(cmd_bl_log.size() - c0), 32'd2);
    if (cmd_bl_log.size() - c0 >= 2 && acc_cyc_log.size() - a0 >= 64) begin
      check("t2_bl0",   32'(cmd_bl_log[c0]),     32'd31);
      check("t2_addr0", 32'(cmd_addr_log[c0]),   32'h000);
      check("t2_bl1",   32'(cmd_bl_log[c0+1]),   32'd31);
      check("t2_addr1", 32'(cmd_addr_log[c0+1]), 32'h080);
      check("t2_lat0",  32'(cmd_cyc_log[c0] - acc_cyc_log[a0+31]),   32'd2);
      check("t2_lat1",  32'(cmd_cyc_log[c0+1] - acc_cyc_log[a0+63]), 32'd2);
    end
    check("t2_bursts", 32'(bursts_issued), 32'd2);

    // Partial burst followed by a full one
    do_reset(); calibrate();
    c0 = cmd_bl_log.size();
    send(5, 32'd100, 1, 0, 0);
    idle(4);
    send(32, 32'd200, 0, 0, 0);
    idle(4);
    check("t3_cmd_count", 32'(cmd_bl_log.size() - c0), 32'd2);
    if (cmd_bl_log.size() - c0 >= 2) begin
      check("t3_bl0",   32'(cmd_bl_log[c0]),     32'd4);
      check("t3_addr0", 32'(cmd_addr_log[c0]),   32'h000);
      check("t3_bl1",   32'(cmd_bl_log[c0+1]),   32'd31);
      check("t3_addr1", 32'(cmd_addr_log[c0+1]), 32'h014);
    end

    // Command FIFO backpressure
    do_reset(); calibrate();
    mig_cmd_full = 1;
    c0 = cmd_bl_log.size();
    send(32, 32'd300, 0, 0, 0);
    repeat (10) begin
      @(negedge clk);
      check("t4_ready_low", 32'(s_ready), 32'd0);
      check("t4_no_pulse",  32'(mig_cmd_en), 32'd0);
      idle(1);
    end
    mig_cmd_full = 0;
    rel = cyc;
    idle(4);
    check("t4_one_pulse", 32'(cmd_bl_log.size() - c0), 32'd1);
    if (cmd_bl_log.size() - c0 >= 1)
      check("t4_pulse_cycle", 32'(cmd_cyc_log[c0] - rel), 32'd1);

    // Write FIFO backpressure with random gaps
    do_reset(); calibrate();
    c0 = cmd_bl_log.size();
    wr_bp = 1;
    send(96, 32'd1000, 0, 20, 0);
    wr_bp = 0;
    idle(6);
    check("t5_cmd_count", 32'(cmd_bl_log.size() - c0), 32'd3);
    check("t5_bursts",    32'(bursts_issued), 32'd3);
    check("t5_all_words", 32'(wr_q.size()), 32'd0);

    // Region wrap, then sticky error
    do_reset(); calibrate();
    c0 = cmd_bl_log.size();
    send(128, $urandom, 0, 10, 0);
    idle(5);
    check("t6_cmd_count", 32'(cmd_bl_log.size() - c0), 32'd4);
    if (cmd_bl_log.size() - c0 >= 4) begin
      check("t6_addr0", 32'(cmd_addr_log[c0]),   32'h00);
      check("t6_addr1", 32'(cmd_addr_log[c0+1]), 32'h80);
      check("t6_addr2", 32'(cmd_addr_log[c0+2]), 32'h00);
      check("t6_addr3", 32'(cmd_addr_log[c0+3]), 32'h80);
    end
    mig_wr_error = 1;
    idle(1);
    mig_wr_error = 0;
    s_valid = 1; s_data = 32'h5555_aaaa;
    repeat (5) begin
      @(negedge clk);
      check("t6_err_sticky", 32'(err), 32'd1);
      check("t6_ready_low",  32'(s_ready), 32'd0);
      idle(1);
    end
    s_valid = 0;
    do_reset();
    @(negedge clk);
    check("t6_err_cleared", 32'(err), 32'd0);
    idle(1);

    // Reset abandons a partial group
    calibrate();
    send(7, 32'd500, 0, 0, 0);
    do_reset(); calibrate();
    c0 = cmd_bl_log.size();
    send(3, 32'd600, 1, 0, 0);
    idle(4);
    check("t7_cmd_count", 32'(cmd_bl_log.size() - c0), 32'd1);
    if (cmd_bl_log.size() - c0 >= 1) begin
      check("t7_bl",   32'(cmd_bl_log[c0]),   32'd2);
      check("t7_addr", 32'(cmd_addr_log[c0]), 32'h000);
    end

    // Random traffic: random s_last, gaps and both backpressures
    do_reset(); calibrate();
    wr_bp = 1; cmd_bp = 1;
    send(300, $urandom, 0, 25, 10);
    wr_bp = 0; cmd_bp = 0;
    mig_cmd_full = 0;
    idle(10);
    check("t8_all_words", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
